// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_pkg
// Purpose  : Shared constants and FSM state type for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Zero        = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : Fetch stage: one memory read per captured PC, buffered toward IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ce,
  output logic              stall_req,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_misalign,
  input  logic              id_ready
);

  state_e              state_q, state_d;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INST_W-1:0]   inst_q;
  logic                misalign_q;
  logic                valid_q;
  logic                capture;
  logic                aligned;

  assign aligned = (pc[1:0] == {Zero, Zero});
  assign capture = (ce == ChipEnable) && (flush == Zero) &&
                   ((state_q == S_IDLE) || ((state_q == S_HOLD) && id_ready));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (capture) state_d = aligned ? S_REQ : S_HOLD;
      end
      S_REQ: begin
        if (mem_gnt)    state_d = flush ? S_DRAIN : S_WAIT;
        else if (flush) state_d = S_IDLE;
      end
      S_WAIT: begin
        // A flush with data in hand just drops it; otherwise the response is still owed.
        if (flush)           state_d = mem_rvalid ? S_IDLE : S_DRAIN;
        else if (mem_rvalid) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (flush)         state_d = S_IDLE;
        else if (id_ready) state_d = capture ? (aligned ? S_REQ : S_HOLD) : S_IDLE;
      end
      S_DRAIN: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      misalign_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == S_REQ);
      valid_q   <= (state_d == S_HOLD);
      if (capture) begin
        mem_addr_q <= pc;
        pc_q       <= pc;
        if (!aligned) begin
          inst_q     <= INST_W'(NOP);
          misalign_q <= 1'b1;
        end
      end else if ((state_q == S_WAIT) && mem_rvalid && (flush == Zero)) begin
        inst_q     <= mem_rdata;
        misalign_q <= 1'b0;
      end
    end
  end

  // Combinational so the PC register sees release in the same cycle decode accepts.
  assign stall_req = !rst &&
                     !((state_q == S_IDLE) || ((state_q == S_HOLD) && id_ready));

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign if_valid    = valid_q;
  assign if_pc       = pc_q;
  assign if_inst     = inst_q;
  assign if_misalign = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Directed and randomized self-checking bench for if_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ce, flush, mem_gnt, mem_rvalid, id_ready;
  logic [31:0] pc, mem_rdata;
  logic        stall_req, mem_req, if_valid, if_misalign;
  logic [31:0] mem_addr, if_pc, if_inst;

  if_fetch #(.ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce), .stall_req(stall_req), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_inst(if_inst), .if_misalign(if_misalign), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   sb_en = 1'b0;

  // Reference memory contents: a fixed scramble of the byte address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_req"},  64'(mem_req),     64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr),    64'd0);
    check({tag, "_if_valid"}, 64'(if_valid),    64'd0);
    check({tag, "_if_pc"},    64'(if_pc),       64'd0);
    check({tag, "_if_inst"},  64'(if_inst),     64'd0);
    check({tag, "_if_mis"},   64'(if_misalign), 64'd0);
    check({tag, "_stall"},    64'(stall_req),   64'd0);
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against the oldest
  // expected fetch, and retires it when decode takes it.
  always @(negedge clk) begin
    if (sb_en && if_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", 64'(if_valid), 64'd0);
      end else begin
        check("sb_pc",   64'(if_pc),       64'(sb_q[0].pc));
        check("sb_inst", 64'(if_inst),     64'(sb_q[0].inst));
        check("sb_mis",  64'(if_misalign), 64'(sb_q[0].mis));
        if (id_ready) void'(sb_q.pop_front());
      end
    end
  end

  // Random-phase memory and PC-source state.
  bit          pend_v = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_a = '0;
  bit          req_waiting = 1'b0;
  logic [31:0] req_addr = '0;
  bit          hold_pc = 1'b0;

  task automatic rand_cycle(input bit allow_new);
    exp_t e;
    step();
    if (req_waiting) begin
      check("req_stable", 64'(mem_req),  64'd1);
      check("addr_stable", 64'(mem_addr), 64'(req_addr));
    end
    mem_rvalid = 1'b0;
    if (pend_v) begin
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memw(pend_a);
        pend_v     = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    mem_gnt = mem_req && ($urandom_range(0, 9) < 6);
    if (mem_gnt) begin
      pend_v   = 1'b1;
      pend_a   = mem_addr;
      pend_cnt = int'($urandom_range(0, 2));
    end
    req_waiting = mem_req && !mem_gnt;
    req_addr    = mem_addr;
    if (!hold_pc) begin
      ce = (allow_new && ($urandom_range(0, 3) != 0)) ? ChipEnable : ChipDisable;
      pc = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 4) == 0) pc[1:0] = 2'($urandom_range(1, 3));
    end
    id_ready = allow_new ? ($urandom_range(0, 2) != 0) : 1'b1;
    @(negedge clk);
    if (ce && !stall_req) begin
      e.pc   = pc;
      e.mis  = (pc[1:0] != 2'b00);
      e.inst = e.mis ? NOP : memw(pc);
      sb_q.push_back(e);
    end
    hold_pc = ce && stall_req;
  endtask

  initial begin
    rst = 1'b1; ce = ChipDisable; pc = '0; flush = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; id_ready = 1'b0;
    step();
    step();
    check_zero("reset");

    // Aligned fetch at 0x0 with zero-wait memory.
    rst = 1'b0; ce = ChipEnable; pc = 32'h0; mem_gnt = 1'b1;
    check("c0_stall", 64'(stall_req), 64'd0);
    step();
    ce = ChipDisable;
    check("c1_mem_req", 64'(mem_req), 64'd1);
    check("c1_mem_addr", 64'(mem_addr), 64'd0);
    check("c1_stall", 64'(stall_req), 64'd1);
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    check("c2_mem_req", 64'(mem_req), 64'd0);
    check("c2_stall", 64'(stall_req), 64'd1);
    check("c2_valid", 64'(if_valid), 64'd0);
    step();
    mem_rvalid = 1'b0;
    check("c3_valid", 64'(if_valid), 64'd1);
    check("c3_inst", 64'(if_inst), 64'hDEAD_BEEF);
    check("c3_pc", 64'(if_pc), 64'd0);
    check("c3_mis", 64'(if_misalign), 64'd0);

    // Back-pressure from decode keeps everything frozen.
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 64'(if_valid), 64'd1);
      check("hold_pc", 64'(if_pc), 64'd0);
      check("hold_inst", 64'(if_inst), 64'hDEAD_BEEF);
      check("hold_stall", 64'(stall_req), 64'd1);
    end
    id_ready = 1'b1; ce = ChipEnable; pc = 32'h8;
    #1;
    check("hold_release_stall", 64'(stall_req), 64'd0);
    step();
    id_ready = 1'b0; ce = ChipDisable;
    check("pc8_mem_req", 64'(mem_req), 64'd1);
    check("pc8_mem_addr", 64'(mem_addr), 64'h8);
    check("pc8_valid", 64'(if_valid), 64'd0);

    // Grant withheld for four cycles.
    for (int i = 0; i < 4; i++) begin
      check("nogrant_req", 64'(mem_req), 64'd1);
      check("nogrant_addr", 64'(mem_addr), 64'h8);
      step();
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    check("late_valid", 64'(if_valid), 64'd1);
    check("late_inst", 64'(if_inst), 64'h1234_5678);
    check("late_pc", 64'(if_pc), 64'h8);

    // Flush while holding.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_hold_valid", 64'(if_valid), 64'd0);
    check("flush_hold_stall", 64'(stall_req), 64'd0);

    // Misaligned PC: no memory access, NOP presented next cycle.
    ce = ChipEnable; pc = 32'h6;
    step();
    ce = ChipDisable;
    check("mis_mem_req", 64'(mem_req), 64'd0);
    check("mis_valid", 64'(if_valid), 64'd1);
    check("mis_inst", 64'(if_inst), 64'h13);
    check("mis_flag", 64'(if_misalign), 64'd1);
    check("mis_pc", 64'(if_pc), 64'h6);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("mis_retire", 64'(if_valid), 64'd0);

    // Flush in WAIT; the response arrives two cycles later and is dropped.
    ce = ChipEnable; pc = 32'h10; mem_gnt = 1'b1;
    step();
    ce = ChipDisable;
    step();
    mem_gnt = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("fw_drain_stall", 64'(stall_req), 64'd1);
    check("fw_valid", 64'(if_valid), 64'd0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step();
    mem_rvalid = 1'b0;
    check("fw_idle_stall", 64'(stall_req), 64'd0);
    check("fw_valid2", 64'(if_valid), 64'd0);

    // Flush coincident with grant.
    ce = ChipEnable; pc = 32'h14;
    step();
    ce = ChipDisable; mem_gnt = 1'b1; flush = 1'b1;
    step();
    mem_gnt = 1'b0; flush = 1'b0;
    check("fg_mem_req", 64'(mem_req), 64'd0);
    check("fg_drain_stall", 64'(stall_req), 64'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD1_BAD1;
    step();
    mem_rvalid = 1'b0;
    check("fg_idle_stall", 64'(stall_req), 64'd0);
    check("fg_valid", 64'(if_valid), 64'd0);

    // Reset during WAIT, then a stale response in IDLE.
    ce = ChipEnable; pc = 32'h18; mem_gnt = 1'b1;
    step();
    ce = ChipDisable;
    step();
    mem_gnt = 1'b0; rst = 1'b1;
    step();
    check_zero("rst_wait");
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD2_BAD2;
    step();
    mem_rvalid = 1'b0;
    check_zero("stale_rvalid");

    // Randomized traffic against the scoreboard.
    sb_en = 1'b1;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 200 && (sb_q.size() != 0 || pend_v || hold_pc); i++) rand_cycle(1'b0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    sb_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage directly downstream of the PC register. Captures the `pc`/`ce` pair, issues one read per PC to instruction memory over a request/grant/response handshake, and buffers the returned word. It then presents the word to the IF/ID boundary with a valid/ready handshake. It back-pressures the PC register through `stall_req` and honours a pipeline `flush`.

## Interface
- `ADDR_W`, default 32: PC and memory address width.
- `INST_W`, default 32: instruction width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc` in ADDR_W: fetch address from the PC register.
- `ce` in 1: `ChipEnable` means `pc` is valid this cycle.
- `stall_req` out 1: PC register must hold `pc` this cycle.
- `flush` in 1: discard all in-flight and buffered work.
- `mem_req` out 1: read request valid.
- `mem_addr` out ADDR_W: read address.
- `mem_gnt` in 1: memory accepts the request this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in INST_W: read data.
- `if_valid` out 1: `if_pc`/`if_inst`/`if_misalign` valid.
- `if_pc` out ADDR_W: PC of the presented instruction.
- `if_inst` out INST_W: fetched instruction.
- `if_misalign` out 1: presented PC had `pc[1:0] != 0`.
- `id_ready` in 1: decode consumes the presented entry this cycle.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
- **Capture:** a new PC is taken when `ce`=`ChipEnable`, `flush`=0, and either the state is IDLE or the state is HOLD with `id_ready`=1.
  - The PC is latched into `mem_addr`, and also into an internal PC register that later drives `if_pc`.
- **Aligned capture** (`pc[1:0]==0`): next state is REQ.
- **Misaligned capture:** next state is HOLD. No memory access is made. `if_inst` is set to `NOP` (0x00000013) and `if_misalign` is set to 1.
- **REQ:** `mem_req`=1. `mem_gnt`=1 moves to WAIT. `mem_req` and `mem_addr` stay stable until granted.
- **WAIT:** `mem_rvalid`=1 latches `mem_rdata` into `if_inst`, clears `if_misalign`, and moves to HOLD.
- **HOLD:** `if_valid`=1.
  - `id_ready`=1 with a capture goes to REQ (aligned PC) or stays in HOLD (misaligned PC).
  - `id_ready`=1 without a capture goes to IDLE.
  - `id_ready`=0 stays in HOLD with all outputs stable.
- **DRAIN:** waits for the orphaned `mem_rvalid`, discards the data, then goes to IDLE.
- **`stall_req`:** 1 in every state except IDLE, and except HOLD with `id_ready`=1. It is 0 while `rst`=1.
- **Flush rules** (`flush` has priority over capture and over `id_ready`):
  - IDLE or HOLD goes to IDLE, and `if_valid` drops the next cycle.
  - REQ without `mem_gnt` goes to IDLE, and `mem_req` drops the next cycle.
  - REQ with `mem_gnt` in the same cycle goes to DRAIN.
  - WAIT without `mem_rvalid` goes to DRAIN.
  - WAIT with `mem_rvalid` goes to IDLE and the data is discarded.
- **Reset:** overrides everything, including mid-transaction. The state goes to IDLE and all registered outputs clear.
  - The memory side must tolerate a dropped response after reset. This is not tracked.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `if_valid`=0, `if_pc`=0, `if_inst`=0, `if_misalign`=0, `stall_req`=0.
- All outputs are registered except `stall_req`, which is combinational from state and `id_ready`.
- Memory must not assert `mem_rvalid` earlier than the cycle after `mem_gnt`.
- Best-case latency for an aligned PC with zero-wait memory:
  - capture at edge N;
  - `mem_req` high in cycle N+1, granted in N+1;
  - `mem_rvalid` in cycle N+2;
  - `if_valid` high in cycle N+3.
- Steady-state throughput with zero-wait memory: one instruction per 3 cycles.
- Latency for a misaligned PC: `if_valid` in the cycle after capture.
- Width rule: `mem_addr` is the full byte address; `pc[1:0]` is used only for the alignment check.

## Structure
- Shared package contents:
  - `ChipEnable`, `ChipDisable` and `Zero` constants;
  - `NOP` (0x00000013);
  - the FSM state enum typedef.
- Single module with no sub-modules; the datapath is three registers plus the FSM.

## Test plan
- Reset, then `ce`=1, `pc`=0x0, memory grants immediately and answers the next cycle:
  - `mem_req` is high in cycle 1;
  - `if_valid` goes high in cycle 3 with `if_inst` equal to the returned word and `if_pc`=0x0;
  - `stall_req` is high in cycles 1–2.
- `pc`=0x6 → no `mem_req`; next cycle `if_valid`=1, `if_inst`=0x00000013, `if_misalign`=1, `if_pc`=0x6.
- `mem_gnt` withheld for 4 cycles → `mem_req` and `mem_addr` are stable throughout; after the grant, the response is presented normally.
- Hold `id_ready`=0 for 5 cycles while in HOLD → `if_valid`, `if_pc`, `if_inst` and `stall_req`=1 all hold. Then `id_ready`=1 with `ce`=1 and `pc`=0x8 → REQ for 0x8 on the next cycle.
- Three flush cases:
  - `flush` in WAIT, with `mem_rvalid` arriving 2 cycles later → the data is dropped, `if_valid` stays 0, then the state returns to IDLE;
  - `flush` in the same cycle as `mem_gnt` → DRAIN;
  - `flush` in HOLD → `if_valid`=0 on the next cycle.
- Assert `rst` during WAIT → all outputs are zero the next cycle and the state is IDLE; a stale `mem_rvalid` in IDLE is ignored.
